regfile32: RTL and testbench

REGFILE32 -- requirements
Module: regfile32

---
 rtl/regfile32.sv | 61 ++++++
 tb/tb_regfile32.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile32.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port, R0 hardwired to zero, and a wrapping commit counter.
module regfile32 #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_reg1,
    input  logic [4:0]            read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [7:0]            write_count
);

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned CNT_WIDTH = 8;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en_c;

    // A write is live only with the enable set and a non-zero destination;
    // gating on reg_write first keeps an undriven write_reg harmless.
    assign write_en_c = reg_write && (write_reg != 5'd0);

    // Storage and commit counter; reset wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (write_en_c) begin
            regs[write_reg] <= write_data;
            write_count     <= write_count + CNT_WIDTH'(1);
        end
    end

    // Read ports: R0 reads zero, a pending write to the same register is forwarded.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != 5'd0) begin
            if (write_en_c && (read_reg1 == write_reg)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end
        if (read_reg2 != 5'd0) begin
            if (write_en_c && (read_reg2 == write_reg)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end
    end

endmodule

// File: tb/tb_regfile32.sv
// Randomized scoreboard bench for regfile32: expectations from an array model
// are queued by the driver and consumed by a negedge monitor.
module tb_regfile32;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [4:0]    read_reg1;
    logic [4:0]    read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [7:0]    write_count;

    regfile32 #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [7:0]    cnt;
    } exp_t;

    exp_t          sb_q[$];
    bit            chk_en = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            tag    = 0;

    // Reference model: plain array of register values plus an unbounded commit tally.
    logic [DW-1:0] mdl [32];
    int            mdl_cnt = 0;

    function automatic logic [DW-1:0] model_read(input logic [4:0] rr);
        if (rr == 5'd0) return '0;
        if (reg_write === 1'b1 && write_reg != 5'd0 && rr == write_reg) return write_data;
        return mdl[rr];
    endfunction

    // Monitor: compare every checked cycle against the queued expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (read_data1 !== e.rd1) begin
                    errors++;
                    $display("FAIL read_data1 tag=%0d got=%h exp=%h", e.tag, read_data1, e.rd1);
                end
                checks++;
                if (read_data2 !== e.rd2) begin
                    errors++;
                    $display("FAIL read_data2 tag=%0d got=%h exp=%h", e.tag, read_data2, e.rd2);
                end
                checks++;
                if (write_count !== e.cnt) begin
                    errors++;
                    $display("FAIL write_count tag=%0d got=%0d exp=%0d", e.tag, write_count, e.cnt);
                end
            end
        end
    end

    // One clock of stimulus. 'glitch' retracts the write after the monitor has
    // sampled the bypass, so storage must follow the value present at the edge.
    task automatic cycle(input logic rst, input logic rw, input logic [4:0] wr,
                         input logic [DW-1:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input bit chk, input bit glitch);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        reg_write  = rw;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        tag++;
        if (chk) begin
            e.tag = tag;
            e.rd1 = model_read(r1);
            e.rd2 = model_read(r2);
            e.cnt = 8'(mdl_cnt % 256);
            sb_q.push_back(e);
        end
        chk_en = chk;
        @(negedge clk);
        #1;
        if (glitch) begin
            reg_write  = 1'b0;
            write_data = ~wd;
        end
        if (reset) begin
            foreach (mdl[i]) mdl[i] = '0;
            mdl_cnt = 0;
        end else if (reg_write === 1'b1 && write_reg != 5'd0) begin
            mdl[write_reg] = write_data;
            mdl_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        foreach (mdl[i]) mdl[i] = '0;

        // Directed scenarios
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 5, 31, 1, 0);
        cycle(0, 1, 7, 32'hDEADBEEF, 7, 0, 1, 0);
        cycle(0, 0, 0, 0, 7, 7, 1, 0);
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 7, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 9, 32'h12345678, 0, 9, 1, 0);
        cycle(0, 0, 0, 0, 7, 9, 1, 0);
        cycle(0, 1, 3, 32'hAAAA0000, 3, 9, 1, 0);
        cycle(0, 0, 0, 0, 3, 9, 1, 0);
        cycle(1, 1, 3, 32'h00005555, 3, 9, 1, 0);
        cycle(0, 0, 0, 0, 3, 9, 1, 0);
        cycle(0, 1, 4, 32'hCAFEF00D, 4, 7, 1, 0);
        cycle(0, 0, 0, 0, 4, 4, 1, 0);
        cycle(0, 1, 12, 32'h0BADBEEF, 12, 12, 1, 1);
        cycle(0, 0, 0, 0, 12, 4, 1, 0);
        cycle(0, 0, 'x, 32'hFFFF0000, 4, 12, 1, 0);
        cycle(0, 0, 0, 0, 4, 1, 1, 0);
        cycle(0, 1, 20, 32'h11111111, 20, 0, 1, 0);
        cycle(0, 1, 20, 32'h22222222, 20, 0, 1, 0);
        cycle(0, 0, 0, 0, 20, 20, 1, 0);

        // Counter wrap: 256 commits after a fresh reset, then full readback
        cycle(1, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            cycle(0, 1, 5'($urandom_range(1, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 0);
        end
        for (int r = 0; r < 32; r += 2) begin
            cycle(0, 0, 0, 0, 5'(r), 5'(r + 1), 1, 0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] wr, r1, r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       r2 = wr;
                1:       r2 = r1;
                default: r2 = 5'($urandom_range(0, 31));
            endcase
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0), wr,
                  $urandom, r1, r2, 1, bit'($urandom_range(0, 15) == 0));
        end

        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
